// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for the 16x16 MAC; streams len operand pairs,
// accumulates products via Kogge-Stone add, returns sum + sticky carry.
module mac_seq_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_acc,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [31:0]      prod_q, prod_d;
  logic             pvld_q, pvld_d;
  logic [31:0]      acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic             start_ok;
  logic             xfer;
  logic [32:0]      sum;

  // 32-bit Kogge-Stone prefix adder, cin = 0.
  // Returns {cout, sum}.
  function automatic logic [32:0] ks_add32(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] g, p, gn, pn, x;
    g = a & b;
    p = a ^ b;
    x = p;
    for (int l = 0; l < 5; l++) begin
      gn = g;
      pn = p;
      for (int i = 0; i < 32; i++) begin
        if (i >= (1 << l)) begin
          gn[i] = g[i] | (p[i] & g[i-(1<<l)]);
          pn[i] = p[i] & p[i-(1<<l)];
        end
      end
      g = gn;
      p = pn;
    end
    return {g[31], x ^ {g[30:0], 1'b0}};
  endfunction

  assign start_ok = (state_q == IDLE) && start;
  assign xfer     = (state_q == RUN) && in_valid;
  assign sum      = ks_add32(acc_q, prod_q);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (in_valid && count_q == LEN_W'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE:  ;
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DRAIN: busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // datapath: product stage then accumulate stage
  always_comb begin
    count_d = count_q;
    prod_d  = prod_q;
    pvld_d  = 1'b0;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (pvld_q) begin
      acc_d = sum[31:0];
      ovf_d = ovf_q | sum[32];
    end
    // a new job wipes the previous result
    if (start_ok) begin
      count_d = len;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end
    if (xfer) begin
      prod_d  = {16'b0, in_a} * {16'b0, in_b};
      pvld_d  = 1'b1;
      count_d = count_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      prod_q  <= '0;
      pvld_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      prod_q  <= prod_d;
      pvld_q  <= pvld_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_acc = acc_q;
  assign out_ovf = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: scoreboard bench for mac_seq_ctrl.
// Expected {ovf,acc} queued at stimulus, popped on out handshake.
module tb_mac_seq_ctrl;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_a = '0;
  logic [15:0]      in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_acc;
  logic             out_ovf;
  logic             busy;

  int n_chk = 0;
  int n_pass = 0;
  logic [32:0] sb[$];
  logic [15:0] va[8];
  logic [15:0] vb[8];

  mac_seq_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [32:0] got,
    input logic [32:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  // scoreboard pop on result handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_depth", 33'(sb.size() != 0), 33'd1);
      if (sb.size() != 0) begin
        check("sb_result", {out_ovf, out_acc}, sb.pop_front());
      end
    end
  end

  task automatic ld(input int i, input logic [15:0] a, input logic [15:0] b);
    va[i] = a;
    vb[i] = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(
    input int    n,
    input int    gap,
    input int    hold,
    input string tag
  );
    logic [31:0] acc;
    logic        ovf;
    logic [32:0] s;
    acc = '0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = {1'b0, acc} + {17'b0, va[i]} * {17'b0, vb[i]};
      ovf = ovf | s[32];
      acc = s[31:0];
    end
    sb.push_back({ovf, acc});
    out_ready = (hold == 0);
    start = 1'b1;
    len = LEN_W'(n);
    tick();
    start = 1'b0;
    if (n == 0) begin
      check({tag, "_rdy"}, 33'(in_ready), 33'd0);
      check({tag, "_vld"}, 33'(out_valid), 33'd1);
    end else begin
      check({tag, "_rdy"}, 33'(in_ready), 33'd1);
      for (int i = 0; i < n; i++) begin
        in_valid = 1'b1;
        in_a = va[i];
        in_b = vb[i];
        tick();
        in_valid = 1'b0;
        if (i < n - 1) begin
          for (int k = 0; k < gap; k++) begin
            check({tag, "_gap_rdy"}, 33'(in_ready), 33'd1);
            tick();
          end
        end
      end
      check({tag, "_drain_vld"}, 33'(out_valid), 33'd0);
      check({tag, "_drain_busy"}, 33'(busy), 33'd1);
      tick();
      check({tag, "_lat2_vld"}, 33'(out_valid), 33'd1);
    end
    for (int k = 0; k < hold; k++) begin
      check({tag, "_hold_vld"}, 33'(out_valid), 33'd1);
      check({tag, "_hold_busy"}, 33'(busy), 33'd1);
      check({tag, "_hold_acc"}, {out_ovf, out_acc}, {ovf, acc});
      tick();
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_exit_vld"}, 33'(out_valid), 33'd0);
    check({tag, "_exit_busy"}, 33'(busy), 33'd0);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_rdy", 33'(in_ready), 33'd0);
    check("rst_vld", 33'(out_valid), 33'd0);
    check("rst_busy", 33'(busy), 33'd0);
    check("rst_out", {out_ovf, out_acc}, 33'd0);
    rst_n = 1'b1;
    tick();

    ld(0, 1, 2); ld(1, 3, 4); ld(2, 5, 6); ld(3, 7, 8);
    run_job(4, 0, 0, "strm");

    ld(0, 16'h10, 16'h10); ld(1, 16'h20, 2); ld(2, 1, 1);
    run_job(3, 1, 3, "bub");

    ld(0, 16'hFFFF, 16'hFFFF); ld(1, 16'hFFFF, 16'hFFFF);
    run_job(2, 0, 1, "ovf");

    ld(0, 2, 3);
    run_job(1, 0, 0, "after_ovf");

    run_job(0, 0, 0, "zero");

    // abort a 5-pair job after 2 transfers
    start = 1'b1;
    len = LEN_W'(5);
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 3;
    in_b = 5;
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    len = LEN_W'(1);
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 7;
    in_b = 2;
    tick();
    in_valid = 1'b0;
    check("run_start_cnt", 33'(dut.count_q), 33'd3);
    check("run_acc", {out_ovf, out_acc}, 33'd15);
    check("run_busy", 33'(busy), 33'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rdy", 33'(in_ready), 33'd0);
    check("arst_vld", 33'(out_valid), 33'd0);
    check("arst_busy", 33'(busy), 33'd0);
    check("arst_out", {out_ovf, out_acc}, 33'd0);
    tick();
    rst_n = 1'b1;
    tick();

    ld(0, 9, 9);
    run_job(1, 0, 0, "post_rst");

    check("sb_left", 33'(sb.size()), 33'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller for the 16-bit MAC unit. It accepts a job length, streams in that many 16x16 unsigned operand pairs over a valid/ready handshake, and registers each product. It accumulates the products into a 32-bit accumulator through the team's 32-bit Kogge-Stone adder (cin tied 0). It then presents the final sum and a sticky overflow flag on a valid/ready output handshake.

## Interface
- LEN_W, 8, width of the job-length input; maximum job is 2^LEN_W-1 pairs
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset; one clock, asynchronous assert, active-low
- start  input  1  job start; sampled only in IDLE
- len  input  LEN_W  number of operand pairs; latched when start is accepted
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller accepts a pair; high only in RUN
- in_a  input  16  multiplicand, unsigned
- in_b  input  16  multiplier, unsigned
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts the result
- out_acc  output  32  accumulator register, driven continuously
- out_ovf  output  1  sticky carry-out of any accumulation in the job
- busy  output  1  high in RUN, DRAIN and DONE

## Operation
- Reset values:
  - state = IDLE
  - in_ready = 0, out_valid = 0, busy = 0
  - out_acc = 0, out_ovf = 0
  - count = 0, product register = 0, product-valid = 0
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and len!=0: load count=len, clear acc and ovf, go to RUN.
  - start=1 and len==0: clear acc and ovf, go to DONE.
  - start=0: stay in IDLE.
- RUN:
  - A transfer occurs on any cycle with in_valid=1 (in_ready is 1 throughout RUN).
  - Each transfer registers in_a*in_b as a 32-bit unsigned product, sets product-valid, and decrements count.
  - A transfer with count==1 moves the FSM to DRAIN.
  - Cycles with in_valid=0 leave the state unchanged.
- Accumulate stage, independent of state:
  - When product-valid=1: acc <= adder sum of acc and product; ovf <= ovf | adder cout.
  - product-valid clears on any cycle without a new transfer.
- DRAIN: lasts exactly one cycle, in which the last product is accumulated, then goes to DONE.
- DONE:
  - out_valid=1; out_acc and out_ovf are held stable.
  - out_ready=1 returns the FSM to IDLE on the next edge.
- start is ignored outside IDLE. start in the same cycle as the DONE->IDLE exit is also ignored.
- Width rules:
  - The product never overflows 32 bits.
  - The accumulator wraps modulo 2^32; any wrap sets out_ovf, which stays set until the next accepted start.
- rst_n asserted at any point (mid-RUN, DRAIN or DONE) immediately forces every reset value; the job in flight is discarded.

## Timing
- Start acceptance: start accepted at edge E gives in_ready=1 in the cycle after E.
- Zero-length job: out_valid=1 in the cycle after E.
- Throughput: one pair per cycle when in_valid is held high.
- Latency: final transfer at edge T gives DRAIN in cycle T+1 and out_valid=1 in cycle T+2, i.e. 2 cycles after the last transfer.
- Result consumption: out_ready sampled at edge R drops out_valid and busy after R. A new start can be accepted at edge R+1 at the earliest.
- Back-to-back: minimum job period is len+3 cycles with out_ready tied high.
- in_ready is a registered function of state only; it has no combinational path from in_valid.

## Test plan
- Continuous stream:
  - Stimulus: len=4, pairs (1,2),(3,4),(5,6),(7,8) on consecutive cycles, out_ready=1.
  - Required: out_acc=100 (0x64), out_ovf=0, out_valid high for exactly 1 cycle, 2 cycles after the 4th transfer.
- Bubbles and backpressure:
  - Stimulus: len=3, pairs (0x10,0x10),(0x20,2),(1,1) with one idle in_valid cycle between each; out_ready low for 3 DONE cycles.
  - Required: out_acc=0x141 held stable, out_valid held, busy=1 until out_ready=1, then IDLE.
- Overflow:
  - Stimulus: len=2, pairs (0xFFFF,0xFFFF) twice.
  - Required: out_acc=0xFFFC0002, out_ovf=1.
  - Follow-up: a following job with len=1, pair (2,3) returns out_acc=6, out_ovf=0.
- Zero length:
  - Stimulus: len=0 with start.
  - Required: in_ready never asserts, out_valid=1 in the next cycle, out_acc=0.
- Reset and ignored start:
  - Stimulus: rst_n pulsed low after 2 of 5 transfers; start pulsed during RUN.
  - Required: all outputs return to reset values asynchronously; start during RUN does not change count.
  - Follow-up: a new job with len=1, pair (9,9) yields out_acc=81.
